// File: rtl/mod_count_pkg.sv
// mod_count_pkg
// Shared definitions for the mod-N counter family and its receive-side monitor.
//   state_t       : monitor FSM states (SEARCH, ACQUIRE, LOCKED)
//   ERR_CNT_WIDTH : width of the saturating error counter
//   ERR_CNT_MAX   : saturation value of the error counter
package mod_count_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int ERR_CNT_WIDTH = 8;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/mod_n_incr.sv
// mod_n_incr
// Combinational modulo-N successor used by the counters and the monitor.
// Ports:
//   value        (in,  WIDTH) : value to examine
//   next_value   (out, WIDTH) : 0 if value == MODULUS-1, else value+1
//   is_wrap      (out, 1)     : value == MODULUS-1
//   out_of_range (out, 1)     : value >= MODULUS
module mod_n_incr #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 3
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] next_value,
  output logic             is_wrap,
  output logic             out_of_range
);

  // MODULUS may equal 2**WIDTH, so the range compare uses one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

  assign is_wrap      = (value == LAST);
  assign out_of_range = ({1'b0, value} >= MOD_EXT);
  assign next_value   = is_wrap ? '0 : value + WIDTH'(1);

endmodule

// File: rtl/mod_n_count_monitor.sv
// mod_n_count_monitor
// Receive-side checker that locks onto a 0..MODULUS-1 count stream, flags
// sequence breaks, counts errors (saturating) and reports locked wraps.
// Ports:
//   clk         (in,  1)     : rising-edge clock
//   reset       (in,  1)     : asynchronous active-low reset
//   count_in    (in,  WIDTH) : observed count sample
//   count_valid (in,  1)     : count_in holds a sample this cycle
//   err_clr     (in,  1)     : synchronous clear of err_count
//   locked      (out, 1)     : FSM is in LOCKED
//   expected    (out, WIDTH) : successor of last accepted in-range sample
//   err_pulse   (out, 1)     : one-cycle pulse per detected error
//   wrap_pulse  (out, 1)     : one-cycle pulse on a locked MODULUS-1 -> 0 step
//   err_count   (out, 8)     : saturating error count
module mod_n_count_monitor
  import mod_count_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 3,
  parameter int LOCK_RUN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     count_valid,
  input  logic                     err_clr,
  output logic                     locked,
  output logic [WIDTH-1:0]         expected,
  output logic                     err_pulse,
  output logic                     wrap_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_RUN + 1);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_inc;

  logic [WIDTH-1:0] sample_next;
  logic             sample_oor;
  logic             unused_sample_wrap;
  logic [WIDTH-1:0] prev_next;
  logic             prev_wrap;
  logic             unused_prev_oor;

  logic             is_succ;
  logic             err_now;

  mod_n_incr #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_incr_sample (
    .value        (count_in),
    .next_value   (sample_next),
    .is_wrap      (unused_sample_wrap),
    .out_of_range (sample_oor)
  );

  mod_n_incr #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_incr_prev (
    .value        (prev),
    .next_value   (prev_next),
    .is_wrap      (prev_wrap),
    .out_of_range (unused_prev_oor)
  );

  assign run_inc = run + RUN_W'(1);
  assign is_succ = (count_in == prev_next);

  // An error is any out-of-range sample, or an in-range break while locked.
  // Breaks during ACQUIRE only restart the run and are not errors.
  always_comb begin
    err_now = 1'b0;
    if (count_valid) begin
      err_now = sample_oor || ((state == LOCKED) && !is_succ);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SEARCH;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      expected   <= '0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      err_pulse  <= err_now;
      wrap_pulse <= 1'b0;
      if (count_valid) begin
        if (sample_oor) begin
          state  <= SEARCH;
          locked <= 1'b0;
        end else begin
          prev     <= count_in;
          expected <= sample_next;
          case (state)
            SEARCH: begin
              run   <= '0;
              state <= ACQUIRE;
            end
            ACQUIRE: begin
              if (is_succ) begin
                run <= run_inc;
                if (run_inc == RUN_W'(LOCK_RUN)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                run <= '0;
              end
            end
            LOCKED: begin
              if (is_succ) begin
                // A correct successor of MODULUS-1 is necessarily 0.
                wrap_pulse <= prev_wrap;
              end else begin
                run    <= '0;
                state  <= ACQUIRE;
                locked <= 1'b0;
              end
            end
            default: begin
              run    <= '0;
              state  <= SEARCH;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // A clear coinciding with an error leaves exactly that one error counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= err_now ? ERR_CNT_WIDTH'(1) : '0;
    end else if (err_now && (err_count != ERR_CNT_MAX)) begin
      err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mod_n_count_monitor.sv
// tb_mod_n_count_monitor
// Scoreboard bench for mod_n_count_monitor (WIDTH=3, MODULUS=3, LOCK_RUN=2).
// Stimulus pushes the hand-computed response for each driven cycle into a
// queue; a monitor pops and compares one cycle-response per clock.
module tb_mod_n_count_monitor;

  typedef struct {
    int         step;
    logic       lk;
    logic [2:0] ex;
    logic       ep;
    logic       wp;
    logic [7:0] ec;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] count_in;
  logic       count_valid;
  logic       err_clr;
  logic       locked;
  logic [2:0] expected;
  logic       err_pulse;
  logic       wrap_pulse;
  logic [7:0] err_count;

  exp_t scoreboard[$];
  int   total;
  int   bad;
  int   stepId;

  mod_n_count_monitor #(.WIDTH(3), .MODULUS(3), .LOCK_RUN(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .count_valid (count_valid),
    .err_clr     (err_clr),
    .locked      (locked),
    .expected    (expected),
    .err_pulse   (err_pulse),
    .wrap_pulse  (wrap_pulse),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkField(input string fld, input int step, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL step %0d %s: got %0d want %0d", step, fld, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("locked",     e.step, int'(locked),     int'(e.lk));
    checkField("expected",   e.step, int'(expected),   int'(e.ex));
    checkField("err_pulse",  e.step, int'(err_pulse),  int'(e.ep));
    checkField("wrap_pulse", e.step, int'(wrap_pulse), int'(e.wp));
    checkField("err_count",  e.step, int'(err_count),  int'(e.ec));
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response
  // expected just after the following rising edge.
  task automatic applyStimulus(input logic vld, input logic [2:0] v, input logic clr,
                               input logic lk, input logic [2:0] ex, input logic ep,
                               input logic wp, input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    count_valid = vld;
    count_in    = v;
    err_clr     = clr;
    stepId++;
    e.step = stepId;
    e.lk = lk; e.ex = ex; e.ep = ep; e.wp = wp; e.ec = ec;
    scoreboard.push_back(e);
  endtask

  // Monitor: the DUT presents a response every clock; pop when one is owed.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t z;
    int   ec;
    total = 0; bad = 0; stepId = 0;
    z.step = 0; z.lk = 0; z.ex = 0; z.ep = 0; z.wp = 0; z.ec = 0;

    reset = 1'b0; count_valid = 1'b0; count_in = '0; err_clr = 1'b0;
    #12;
    checkOutput(z);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] lock and wrap");
    applyStimulus(1, 3'd0, 0,  0, 3'd1, 0, 0, 8'd0);
    applyStimulus(1, 3'd1, 0,  0, 3'd2, 0, 0, 8'd0);
    applyStimulus(1, 3'd2, 0,  1, 3'd0, 0, 0, 8'd0);
    applyStimulus(1, 3'd0, 0,  1, 3'd1, 0, 1, 8'd0);

    $display("[TB] sequence break and relock");
    applyStimulus(1, 3'd1, 0,  1, 3'd2, 0, 0, 8'd0);
    applyStimulus(1, 3'd1, 0,  0, 3'd2, 1, 0, 8'd1);
    applyStimulus(1, 3'd2, 0,  0, 3'd0, 0, 0, 8'd1);
    applyStimulus(1, 3'd0, 0,  1, 3'd1, 0, 0, 8'd1);

    $display("[TB] out of range while locked");
    applyStimulus(0, 3'd0, 1,  1, 3'd1, 0, 0, 8'd0);
    applyStimulus(1, 3'd3, 0,  0, 3'd1, 1, 0, 8'd1);
    applyStimulus(1, 3'd5, 0,  0, 3'd1, 1, 0, 8'd2);

    $display("[TB] valid gaps");
    applyStimulus(1, 3'd0, 0,  0, 3'd1, 0, 0, 8'd2);
    applyStimulus(0, 3'd7, 0,  0, 3'd1, 0, 0, 8'd2);
    applyStimulus(1, 3'd1, 0,  0, 3'd2, 0, 0, 8'd2);
    applyStimulus(0, 3'd0, 0,  0, 3'd2, 0, 0, 8'd2);
    applyStimulus(0, 3'd5, 0,  0, 3'd2, 0, 0, 8'd2);
    applyStimulus(1, 3'd2, 0,  1, 3'd0, 0, 0, 8'd2);

    $display("[TB] saturation and clear");
    for (int i = 0; i < 300; i++) begin
      ec = (i + 3 > 255) ? 255 : i + 3;
      applyStimulus(1, 3'd7, 0,  0, 3'd0, 1, 0, 8'(ec));
    end
    applyStimulus(1, 3'd6, 1,  0, 3'd0, 1, 0, 8'd1);
    applyStimulus(0, 3'd0, 1,  0, 3'd0, 0, 0, 8'd0);

    $display("[TB] async reset while locked");
    applyStimulus(1, 3'd7, 0,  0, 3'd0, 1, 0, 8'd1);
    applyStimulus(1, 3'd7, 0,  0, 3'd0, 1, 0, 8'd2);
    applyStimulus(1, 3'd7, 0,  0, 3'd0, 1, 0, 8'd3);
    applyStimulus(1, 3'd7, 0,  0, 3'd0, 1, 0, 8'd4);
    applyStimulus(1, 3'd0, 0,  0, 3'd1, 0, 0, 8'd4);
    applyStimulus(1, 3'd1, 0,  0, 3'd2, 0, 0, 8'd4);
    applyStimulus(1, 3'd2, 0,  1, 3'd0, 0, 0, 8'd4);
    @(posedge clk);
    #2;
    count_valid = 1'b0;
    reset = 1'b0;
    #1;
    z.step = -1;
    checkOutput(z);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 3'd0, 0,  0, 3'd1, 0, 0, 8'd0);
    applyStimulus(1, 3'd1, 0,  0, 3'd2, 0, 0, 8'd0);
    applyStimulus(1, 3'd2, 0,  1, 3'd0, 0, 0, 8'd0);
    applyStimulus(1, 3'd0, 0,  1, 3'd1, 0, 1, 8'd0);
    @(posedge clk);
    #2;
    count_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkField("queue_drained", -2, scoreboard.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_n_count_monitor.md
# mod_n_count_monitor

Receive-side checker for the mod-N counters in this design. It consumes a sampled count stream and locks onto the expected modulo sequence 0, 1, …, MODULUS-1, 0, … It flags every sequence break, counts errors, and reports wraps. It sits beside any `mod_*_counter` instance, or at the far end of a link that carries its count, as the observing end of that interface.

## Interface
- `WIDTH`, default 3: width of the observed count.
- `MODULUS`, default 3: counter modulus. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.
- `LOCK_RUN`, default 2: consecutive correct successors required to lock. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `reset`, input, 1: reset is asynchronous and active-low; `reset`=0 clears all state immediately.
- `count_in`, input, WIDTH: observed count value.
- `count_valid`, input, 1: `count_in` is a sample this cycle.
- `err_clr`, input, 1: synchronous clear of `err_count`.
- `locked`, output, 1: high while the FSM is in LOCKED.
- `expected`, output, WIDTH: successor of the last accepted in-range sample.
- `err_pulse`, output, 1: one-cycle pulse per detected error.
- `wrap_pulse`, output, 1: one-cycle pulse on a locked MODULUS-1 → 0 transition.
- `err_count`, output, 8: saturating error count.

## Operation
- Successor rule: next(v) = 0 if v == MODULUS-1, else v+1. A value v ≥ MODULUS is out-of-range.
- Registers: `state`, `prev` (WIDTH bits), `run` (counts 0..LOCK_RUN).
- Cycles with `count_valid`=0: all state holds and both pulses stay 0.
- FSM with `count_valid`=1 and sample v:
  - SEARCH:
    - v in range → prev=v, run=0, go to ACQUIRE.
    - v out of range → err_pulse, stay in SEARCH.
  - ACQUIRE:
    - v == next(prev) → prev=v, run+1. When run reaches LOCK_RUN, go to LOCKED.
    - Otherwise in range → prev=v, run=0, stay in ACQUIRE. No error is flagged.
    - v out of range → err_pulse, go to SEARCH.
  - LOCKED:
    - v == next(prev) → prev=v. Assert wrap_pulse if v==0.
    - Otherwise in range → err_pulse, prev=v, run=0, go to ACQUIRE.
    - v out of range → err_pulse, go to SEARCH.
- `expected` loads next(v) on every accepted in-range sample. It holds on out-of-range samples and on idle cycles.
- `err_count`:
  - +1 per err_pulse, saturating at 255.
  - `err_clr` alone → 0.
  - `err_clr` in the same cycle as an error → 1.
- Reset values:
  - state=SEARCH, prev=0, run=0.
  - locked=0, expected=0, err_pulse=0, wrap_pulse=0, err_count=0.

## Timing
- All outputs are registered. The response to the sample at edge k appears after edge k and is valid through edge k+1 (1-cycle latency).
- `locked` rises in the cycle after the sample that completes LOCK_RUN. It falls in the cycle after the first error sample.
- Pulses are exactly 1 cycle wide. Back-to-back error samples give back-to-back pulses.
- Asserting `reset` mid-operation forces the reset values without waiting for `clk`. The first sample after `reset` is released is treated as a SEARCH-state sample.

## Structure
- Shared package `mod_count_pkg` holds:
  - the state encoding constants SEARCH, ACQUIRE, LOCKED;
  - ERR_CNT_WIDTH=8 and ERR_CNT_MAX=255.
- One natural combinational sub-module, `mod_n_incr`, parameterised by WIDTH and MODULUS. It outputs next(v), `is_wrap` (v==MODULUS-1) and `out_of_range` (v ≥ MODULUS). The counters can reuse it.
- The top level holds the FSM, `prev`/`run`, the error counter and the output registers.

## Test plan
All scenarios use WIDTH=3, MODULUS=3, LOCK_RUN=2.
1. Lock and wrap: release reset, then stream 0,1,2,0 with valid every cycle → `locked`=1 the cycle after sample 2; `wrap_pulse`=1 one cycle after the final 0; `err_count`=0; `expected`=1 at end.
2. Sequence break: while locked, drive 1,1 → one `err_pulse`, `err_count`=1, `locked`=0. Then drive 2,0 → relock after sample 0, no further error.
3. Out-of-range: while locked, drive 3 → `err_pulse`, FSM goes to SEARCH, `expected` unchanged. Then drive 5 → second pulse, `err_count`=2.
4. Valid gaps: stream 0,–,1,–,–,2 with valid low on the dashes → locks after sample 2, no `err_pulse`; outputs hold during the gaps.
5. Counter saturation and clear:
   - 300 out-of-range samples → `err_count`=255.
   - `err_clr` together with an error sample → `err_count`=1.
   - `err_clr` alone → `err_count`=0.
6. Async reset: drop `reset` between clock edges while locked with `err_count`=4 → all outputs reach their reset values before the next `clk` edge. After release, 0,1,2 relocks normally.
